// File: rtl/ps2_host.sv
// PS/2 host transceiver: debounced clock, rx FIFO, tx with retry, watchdog.
// Pads live outside; this block only drives the open-drain output enables.
module ps2_host #(
  parameter int CLK_HZ      = 25_125_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEBOUNCE    = 5,
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       rx_overflow,
  output logic       busy
);
  localparam int T100 = (CLK_HZ + 9_999) / 10_000;
  localparam int T20  = (CLK_HZ + 49_999) / 50_000;
  localparam longint TWD_L =
    (longint'(CLK_HZ) * longint'(TIMEOUT_US) + 64'd999_999)
    / 64'd1_000_000;
  localparam int TWD = int'(TWD_L);
  localparam int TMW = $clog2(T100) + 1;
  localparam int WDW = $clog2(TWD) + 1;
  localparam int RW  = $clog2(MAX_RETRIES + 1) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE, RX, INHIBIT, REQ, TXB, ACK, WAIT
  } state_t;

  state_t state, state_n;

  logic [DEBOUNCE-1:0] hist;
  logic lvl, clk_lo, clk_hi, fall, rise;

  assign clk_lo = ~|hist;
  assign clk_hi = &hist;
  assign fall   = lvl & clk_lo;
  assign rise   = ~lvl & clk_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '1;
      lvl  <= 1'b1;
    end else begin
      hist <= {hist[DEBOUNCE-2:0], ps2_clk_i};
      if (fall)      lvl <= 1'b0;
      else if (rise) lvl <= 1'b1;
    end
  end

  logic [TMW-1:0] tmr, tmr_n;
  logic [WDW-1:0] wd, wd_n;
  logic [RW-1:0]  retry, retry_n;
  logic [3:0]     bitcnt, bitcnt_n;
  logic [9:0]     sh, sh_n;
  logic clk_oe_n, data_oe_n;
  logic done_n, txerr_n, rxerr_n, ovf_n;
  logic push, pop, full, frame_ok, wd_on;

  assign frame_ok = ~sh[0] & ps2_data_i & (^sh[9:1]);
  assign wd_on    = state inside {RX, TXB, ACK, WAIT};
  assign tx_ready = (state == IDLE) && !clk_lo;
  assign busy     = state != IDLE;

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    wd_n      = '0;
    retry_n   = retry;
    bitcnt_n  = bitcnt;
    sh_n      = sh;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    txerr_n   = 1'b0;
    rxerr_n   = 1'b0;
    ovf_n     = 1'b0;
    push      = 1'b0;
    if (wd_on && !fall && !rise) wd_n = wd + 1'b1;
    unique case (state)
      IDLE: begin
        if (clk_lo) begin
          state_n  = RX;
          bitcnt_n = '0;
          if (fall) begin
            sh_n     = {ps2_data_i, sh[9:1]};
            bitcnt_n = 4'd1;
          end
        end else if (tx_valid) begin
          sh_n     = {1'b1, ~^tx_data, tx_data};
          retry_n  = '0;
          tmr_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      RX: begin
        if (fall) begin
          if (bitcnt == 4'd10) begin
            state_n = WAIT;
            if (!frame_ok)        rxerr_n = 1'b1;
            else if (full && !pop) ovf_n  = 1'b1;
            else                   push   = 1'b1;
          end else begin
            sh_n     = {ps2_data_i, sh[9:1]};
            bitcnt_n = bitcnt + 4'd1;
          end
        end
      end
      INHIBIT: begin
        if (tmr == TMW'(T100 - 1)) begin
          tmr_n     = '0;
          data_oe_n = 1'b1;
          state_n   = REQ;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      REQ: begin
        if (tmr == TMW'(T20 - 1)) begin
          clk_oe_n = 1'b0;
          bitcnt_n = '0;
          state_n  = TXB;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      TXB: begin
        // rotate so the frame is intact again for a retry
        if (fall) begin
          data_oe_n = ~sh[0];
          sh_n      = {sh[0], sh[9:1]};
          bitcnt_n  = bitcnt + 4'd1;
          if (bitcnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (!ps2_data_i) begin
            done_n  = 1'b1;
            state_n = WAIT;
          end else if (retry < RW'(MAX_RETRIES)) begin
            retry_n  = retry + 1'b1;
            tmr_n    = '0;
            clk_oe_n = 1'b1;
            state_n  = INHIBIT;
          end else begin
            txerr_n = 1'b1;
            state_n = WAIT;
          end
        end
      end
      WAIT: if (clk_hi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wd_on && !fall && !rise && wd == WDW'(TWD - 1)) begin
      state_n   = IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      push      = 1'b0;
      rxerr_n   = state == RX;
      txerr_n   = state inside {TXB, ACK};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmr         <= '0;
      wd          <= '0;
      retry       <= '0;
      bitcnt      <= '0;
      sh          <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      rx_err      <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      state       <= state_n;
      tmr         <= tmr_n;
      wd          <= wd_n;
      retry       <= retry_n;
      bitcnt      <= bitcnt_n;
      sh          <= sh_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_error    <= txerr_n;
      rx_err      <= rxerr_n;
      rx_overflow <= ovf_n;
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] count, count_n;
  logic [7:0]    head_n;

  assign pop     = rx_valid & rx_ready;
  assign full    = count == CW'(FIFO_DEPTH);
  assign rptr_n  = rptr + AW'(pop);
  assign count_n = count + CW'(push) - CW'(pop);
  // head bypass: the slot being written this cycle is the next head
  assign head_n  = (push && rptr_n == wptr) ? sh[8:1] : mem[rptr_n];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sh[8:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      wptr     <= wptr + AW'(push);
      rptr     <= rptr_n;
      count    <= count_n;
      rx_valid <= count_n != '0;
      rx_data  <= head_n;
    end
  end
endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: device-side PS/2 model on both wires.
// Scaled clock so T100=100, T20=20, TWD=2000 cycles.
module tb_ps2_host;
  localparam int HP = 20;
  localparam int DB = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, tx_done, tx_error;
  logic rx_valid, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_err, rx_overflow, busy;

  int checks = 0;
  int errors = 0;
  int n_rxerr = 0, n_ovf = 0, n_done = 0, n_txerr = 0;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host #(
    .CLK_HZ(1_000_000), .FIFO_DEPTH(8), .DEBOUNCE(DB),
    .MAX_RETRIES(3), .TIMEOUT_US(2000)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_err(rx_err), .rx_overflow(rx_overflow), .busy(busy)
  );

  always @(posedge clk) begin
    if (rx_err)      n_rxerr++;
    if (rx_overflow) n_ovf++;
    if (tx_done)     n_done++;
    if (tx_error)    n_txerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dev_bit(input logic b);
    dev_data = b;
    repeat (HP / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HP) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HP / 2) @(negedge clk);
  endtask

  task automatic dev_send(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
    for (int i = 0; i < 11; i++) dev_bit(f[i]);
    dev_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic wait_oe(input logic want, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (ps2_clk_oe === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic dev_take(input logic ack, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_data = ~ack;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_data_i;
    end
    dev_data = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    int base, cnt, attempts;
    bit ok;
    logic [9:0] bits;
    logic [10:0] f;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);

    // 1: good frame 0x1C, parity 0, with latency check
    base = n_rxerr;
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) dev_bit(f[i]);
    dev_data = 1'b1;
    repeat (HP / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (DB + 2) @(negedge clk);
    chk("t1_latency", 32'(rx_valid), 32'd1);
    repeat (HP - DB - 2) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HP) @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd0);
    pop_chk("t1_pop", 8'h1C);
    chk("t1_rxerr", 32'(n_rxerr - base), 32'd0);
    chk("t1_empty", 32'(rx_valid), 32'd0);

    // 2: bad parity
    base = n_rxerr;
    dev_send(8'h1C, 1'b1);
    chk("t2_rxerr", 32'(n_rxerr - base), 32'd1);
    chk("t2_empty", 32'(rx_valid), 32'd0);

    // 3: nine bytes into an 8-deep FIFO
    base = n_ovf;
    for (int b = 1; b <= 9; b++) dev_send(8'(b), ~^(8'(b)));
    chk("t3_ovf", 32'(n_ovf - base), 32'd1);
    for (int b = 1; b <= 8; b++) pop_chk("t3_pop", 8'(b));
    @(negedge clk);
    chk("t3_empty", 32'(rx_valid), 32'd0);

    // 4: tx 0xED, device acks; 0xED has six ones so parity is 1
    base = n_done;
    send_tx(8'hED);
    wait_oe(1'b1, 10, ok);
    chk("t4_inhibit", 32'(ok), 32'd1);
    cnt = 0;
    while (!ps2_data_oe && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_t100", 32'(cnt), 32'd100);
    cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_t20", 32'(cnt), 32'd20);
    chk("t4_start", 32'(ps2_data_i), 32'd0);
    dev_take(1'b1, bits);
    chk("t4_data", 32'(bits[7:0]), 32'hED);
    chk("t4_parity", 32'(bits[8]), 32'd1);
    chk("t4_stop", 32'(bits[9]), 32'd1);
    repeat (HP) @(negedge clk);
    chk("t4_done", 32'(n_done - base), 32'd1);
    chk("t4_ready", 32'(tx_ready), 32'd1);

    // 5: tx 0xF4, device never acks
    base = n_txerr;
    send_tx(8'hF4);
    attempts = 0;
    for (int a = 0; a < 6; a++) begin
      wait_oe(1'b1, 300, ok);
      if (!ok) break;
      attempts++;
      wait_oe(1'b0, 300, ok);
      if (!ok) break;
      dev_take(1'b0, bits);
    end
    chk("t5_attempts", 32'(attempts), 32'd4);
    chk("t5_txerr", 32'(n_txerr - base), 32'd1);
    chk("t5_ready", 32'(tx_ready), 32'd1);

    // 6: device stalls after bit 5, then a clean 0xAA
    base = n_rxerr;
    f = {1'b1, 1'b1, 8'hAA, 1'b0};
    for (int i = 0; i < 6; i++) dev_bit(f[i]);
    dev_data = 1'b1;
    repeat (1900) @(negedge clk);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    chk("t6_pre_rxerr", 32'(n_rxerr - base), 32'd0);
    repeat (200) @(negedge clk);
    chk("t6_rxerr", 32'(n_rxerr - base), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_nopush", 32'(rx_valid), 32'd0);
    dev_send(8'hAA, 1'b1);
    pop_chk("t6_pop", 8'hAA);
    chk("t6_rxerr2", 32'(n_rxerr - base), 32'd1);

    // reset mid-frame drops the clock pull at once
    send_tx(8'h55);
    wait_oe(1'b1, 10, ok);
    chk("rst_mid_oe_set", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
